regfile_dump_reader: RTL and testbench
======================================

# regfile_dump_reader

Debug-side reader for the processor register file: on a start pulse it freezes register writes, walks read addresses 0..31 through a spare register-file read port, and streams each 32-bit value out over a valid/ready interface. It sits between the core's register file and the debug/trace path. While the dump runs, it holds the write-back path so the snapshot is coherent.

## Interface
Parameters:
- N, 32, data width of one register
- NUM_REGS, 32, registers dumped (index width 5)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  single-cycle request to begin a dump; sampled only in IDLE
- rd_sel  out  5  read address to the register-file read port
- rd_data  in  N  combinational read data returned for rd_sel
- core_hold  out  1  forces the core's RegWrite low while high
- busy  out  1  high from the cycle after start is accepted until DONE ends
- done  out  1  one-cycle pulse after the final beat handshake
- out_valid  out  1  stream beat valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  N  register value (or checksum)
- out_index  out  5  register number of the current beat
- out_last  out  1  marks the final beat of the dump

## Operation
- FSM states: IDLE, HOLD, READ, SEND, CSUM (macro only), DONE.
- IDLE: if start=1, go to HOLD and clear idx and the checksum. start in any other state is ignored.
- HOLD: core_hold=1 for one cycle so an in-flight write can retire, then go to READ.
- READ: rd_sel=idx. out_data<=rd_data, out_index<=idx, and checksum^=rd_data are captured at the clock edge. Then go to SEND.
- SEND: out_valid=1, and out_data/out_index/out_last stay stable until out_valid&&out_ready. On handshake:
  - if idx<31: idx++ and go to READ;
  - if idx=31: go to CSUM (macro on) or DONE.
- out_last=1 on the idx=31 beat without the macro, or on the CSUM beat with it.
- DONE: done=1 for one cycle, then IDLE.
- core_hold=1 and busy=1 in every state except IDLE.
- rd_sel=idx in all non-IDLE states and 0 in IDLE.
- idx is 5 bits and never wraps inside a dump; the transition at 31 ends the walk.
- Reset values: all outputs 0, state IDLE, idx 0, checksum 0.
- Reset mid-dump aborts immediately: core_hold drops, no done pulse is produced, and the partial stream is discarded.

## Timing
- start sampled high at edge 0 → HOLD in cycle 1, READ in cycle 2, first out_valid in cycle 3.
- Minimum 2 cycles per beat (READ+SEND).
- With out_ready held at 1:
  - data beats occur at cycles 3, 5, …, 65;
  - done in cycle 66, or 67 when the checksum beat occupies cycle 66.
- Each out_ready=0 cycle in SEND adds exactly one cycle.
- rd_data is assumed valid in the same cycle as rd_sel (combinational register-file read).

## Configuration
- REGDUMP_CHECKSUM_EN defined:
  - a 33rd beat is appended in state CSUM, with out_data = XOR of all 32 values, out_index=0 and out_last=1;
  - the idx=31 data beat has out_last=0.
- REGDUMP_CHECKSUM_EN undefined: exactly 32 beats, no CSUM state, and no checksum register is synthesized.

## Structure
- Package regdump_pkg holds:
  - the state enum (IDLE, HOLD, READ, SEND, CSUM, DONE);
  - NUM_REGS=32, IDX_W=5, LAST_IDX=5'd31.
- One sub-module, regdump_xor_acc: N-bit XOR accumulator with clear/enable ports and the same clk/reset. It is instantiated only under REGDUMP_CHECKSUM_EN.

## Test plan
- Reset, then dump with out_ready=1:
  - 32 beats with out_index 0..31;
  - beat 2 data = 124 (sp reset value), all other beats 0;
  - done pulse in cycle 66.
- Write 0xA5A5_0000+i to registers 1..31 (register 0 ignores writes), then dump:
  - each beat i carries 0xA5A5_0000+i for i≥1 and 0 for register 0;
  - out_last is high only on the final beat.
- Back-pressure: toggle out_ready 0/1 pseudo-randomly → out_data/out_index remain stable while valid && !ready, and there are no dropped or duplicated beats.
- During a dump, the core attempts writes each cycle and start is pulsed again:
  - core_hold stays 1 from cycle 1 to done, so the register contents are unchanged;
  - the second start is ignored and exactly one dump is produced.
- Assert reset at beat 10 → on the next cycle all outputs are 0 and core_hold=0, with no done pulse; a new start then yields a full 32-beat dump.
- REGDUMP_CHECKSUM_EN with the write pattern above → 33rd beat = XOR over i=1..31 of (0xA5A5_0000+i), with out_last=1 only on that beat.

Source files
------------

// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump reader.
// The optional checksum beat is enabled by defining REGDUMP_CHECKSUM_EN.
package regdump_pkg;

   localparam int NUM_REGS = 32;
   localparam int IDX_W    = 5;
   localparam logic [IDX_W-1:0] LAST_IDX = 5'd31;

   typedef enum logic [2:0] {
      IDLE,
      HOLD,
      READ,
      SEND,
      CSUM,
      DONE
   } state_e;

endpackage

// File: rtl/regdump_xor_acc.sv
// N-bit XOR accumulator that builds the running checksum of a dump.
// It is only instantiated when REGDUMP_CHECKSUM_EN is defined.
module regdump_xor_acc #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [N-1:0] data_i,
   output logic [N-1:0] acc_o
);

   logic [N-1:0] acc_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q <= '0;
      end else if (clr_i) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= acc_q ^ data_i;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Freezes register write-back, walks read addresses 0..NUM_REGS-1 and streams each value out.
// Defining REGDUMP_CHECKSUM_EN appends an XOR checksum beat after the last register.
module regfile_dump_reader #(
   parameter int N        = 32,
   parameter int NUM_REGS = regdump_pkg::NUM_REGS
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic [4:0]   rd_sel,
   input  logic [N-1:0] rd_data,
   output logic         core_hold,
   output logic         busy,
   output logic         done,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic [4:0]   out_index,
   output logic         out_last
);

   import regdump_pkg::*;

   localparam logic [IDX_W-1:0] LAST = (NUM_REGS == regdump_pkg::NUM_REGS) ?
                                       LAST_IDX : IDX_W'(NUM_REGS - 1);

   state_e           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] rd_sel_q;
   logic             core_hold_q;
   logic             busy_q;
   logic             done_q;
   logic             out_valid_q;
   logic [N-1:0]     out_data_q;
   logic [IDX_W-1:0] out_index_q;
   logic             out_last_q;

`ifdef REGDUMP_CHECKSUM_EN
   logic [N-1:0] csum;

   regdump_xor_acc #(.N(N)) u_xor_acc (
      .clk    (clk),
      .reset  (reset),
      .clr_i  ((state_q == IDLE) && start),
      .en_i   (state_q == READ),
      .data_i (rd_data),
      .acc_o  (csum)
   );
`endif

   // All outputs are registered and updated together with the state they belong to.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         rd_sel_q    <= '0;
         core_hold_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_last_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q     <= HOLD;
                  idx_q       <= '0;
                  rd_sel_q    <= '0;
                  core_hold_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            HOLD: state_q <= READ;
            READ: begin
               out_data_q  <= rd_data;
               out_index_q <= idx_q;
`ifdef REGDUMP_CHECKSUM_EN
               out_last_q  <= 1'b0;
`else
               out_last_q  <= (idx_q == LAST);
`endif
               out_valid_q <= 1'b1;
               state_q     <= SEND;
            end
            SEND: begin
               if (out_ready) begin
                  if (idx_q != LAST) begin
                     out_valid_q <= 1'b0;
                     idx_q       <= idx_q + 1'b1;
                     rd_sel_q    <= idx_q + 1'b1;
                     state_q     <= READ;
                  end else begin
`ifdef REGDUMP_CHECKSUM_EN
                     out_data_q  <= csum;
                     out_index_q <= '0;
                     out_last_q  <= 1'b1;
                     state_q     <= CSUM;
`else
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= DONE;
`endif
                  end
               end
            end
`ifdef REGDUMP_CHECKSUM_EN
            CSUM: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end
            end
`endif
            DONE: begin
               core_hold_q <= 1'b0;
               busy_q      <= 1'b0;
               rd_sel_q    <= '0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rd_sel    = rd_sel_q;
   assign core_hold = core_hold_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_index = out_index_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register file and write port.
// Follows REGDUMP_CHECKSUM_EN to expect the extra checksum beat.
module tb_regfile_dump_reader;

   localparam int N = 32;
`ifdef REGDUMP_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [4:0]   rd_sel;
   logic [N-1:0] rd_data;
   logic         core_hold;
   logic         busy;
   logic         done;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;
   logic [4:0]   out_index;
   logic         out_last;

   logic         rf_init;
   logic         wr_en;
   logic [4:0]   wr_addr;
   logic [31:0]  wr_data;
   logic [31:0]  regs [32];
   logic [31:0]  snap [32];
   logic [31:0]  last_csum;

   int checks = 0;
   int errors = 0;

   regfile_dump_reader #(.N(N), .NUM_REGS(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rd_sel    (rd_sel),
      .rd_data   (rd_data),
      .core_hold (core_hold),
      .busy      (busy),
      .done      (done),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   // Register file: x0 hard-wired, sp (x2) resets to 124, writes gated by core_hold.
   assign rd_data = regs[rd_sel];
   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 32; i++) regs[i] <= (i == 2) ? 32'd124 : 32'd0;
      end else if (wr_en && !core_hold && wr_addr != 5'd0) begin
         regs[wr_addr] <= wr_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Caller sits on a negedge with the DUT idle; one cycle after return the DUT is idle again.
   task automatic do_dump(input bit bp, input bit hammer);
      int          cyc;
      int          beats;
      int          stalls;
      bit          prev_stall;
      bit          got_done;
      logic [31:0] prev_data;
      logic [4:0]  prev_idx;
      logic [31:0] xacc;
      beats = 0; stalls = 0; prev_stall = 0; got_done = 0; xacc = '0;
      prev_data = '0; prev_idx = '0;
      for (int i = 0; i < 32; i++) begin
         snap[i] = regs[i];
         xacc ^= regs[i];
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      check("hold_c1", {31'd0, core_hold}, 32'd1);
      check("busy_c1", {31'd0, busy}, 32'd1);
      while (!got_done && cyc < 2000) begin
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (hammer) begin
            wr_en   = 1'b1;
            wr_addr = 5'($urandom_range(1, 31));
            wr_data = $urandom;
            start   = (cyc == 10 || cyc == 40);
            check("hold_run", {31'd0, core_hold}, 32'd1);
         end
         if (prev_stall) begin
            check("stable_data", out_data, prev_data);
            check("stable_idx", {27'd0, out_index}, {27'd0, prev_idx});
         end
         if (out_valid && out_ready) begin
            if (beats < 32) begin
               check("beat_idx", {27'd0, out_index}, 32'(beats));
               check("beat_data", out_data, snap[beats]);
               check("beat_last", {31'd0, out_last}, {31'd0, (CS == 0 && beats == 31)});
               check("beat_cyc", 32'(cyc), 32'(3 + 2 * beats + stalls));
            end else begin
               last_csum = out_data;
               check("csum_idx", {27'd0, out_index}, 32'd0);
               check("csum_data", out_data, xacc);
               check("csum_last", {31'd0, out_last}, 32'd1);
               check("csum_cyc", 32'(cyc), 32'(66 + stalls));
            end
            beats++;
         end
         prev_stall = out_valid && !out_ready;
         if (prev_stall) stalls++;
         prev_data = out_data;
         prev_idx  = out_index;
         if (done) begin
            got_done = 1;
            check("beat_count", 32'(beats), 32'(32 + CS));
            check("done_cyc", 32'(cyc), 32'(66 + CS + stalls));
         end
         @(negedge clk);
         cyc++;
      end
      wr_en = 1'b0;
      start = 1'b0;
      out_ready = 1'b1;
      check("done_seen", {31'd0, got_done}, 32'd1);
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_hold", {31'd0, core_hold}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      if (hammer) begin
         for (int i = 0; i < 32; i++) check("rf_frozen", regs[i], snap[i]);
      end
   endtask

   initial begin
      bit found;
      bit saw_done;
      reset = 1'b0; rf_init = 1'b1; start = 1'b0; out_ready = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; last_csum = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_hold", {31'd0, core_hold}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_last", {31'd0, out_last}, 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_sel", {27'd0, rd_sel}, 32'd0);
      check("rst_index", {27'd0, out_index}, 32'd0);
      rf_init = 1'b0;
      reset = 1'b1;
      @(negedge clk);

      // Register file straight out of reset: only sp is non-zero.
      do_dump(1'b0, 1'b0);
      check("sp_beat", snap[2], 32'd124);

      for (int i = 0; i < 32; i++) begin
         wr_en = 1'b1;
         wr_addr = 5'(i);
         wr_data = (i == 0) ? 32'hDEAD_BEEF : 32'hA5A5_0000 + 32'(i);
         @(negedge clk);
      end
      wr_en = 1'b0;
      @(negedge clk);
      check("rf_x0", regs[0], 32'd0);
      check("rf_x31", regs[31], 32'hA5A5_001F);
      do_dump(1'b0, 1'b0);
`ifdef REGDUMP_CHECKSUM_EN
      check("csum_const", last_csum, 32'hA5A5_0000);
`endif

      do_dump(1'b1, 1'b0);
      do_dump(1'b0, 1'b1);

      // Abort mid-dump with reset while beat 10 is presented.
      found = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         out_ready = 1'b1;
         if (out_valid && out_index == 5'd10) found = 1;
         else @(negedge clk);
      end
      check("abort_found", {31'd0, found}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check("abort_valid", {31'd0, out_valid}, 32'd0);
      check("abort_hold", {31'd0, core_hold}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_data", out_data, 32'd0);
      check("abort_index", {27'd0, out_index}, 32'd0);
      check("abort_sel", {27'd0, rd_sel}, 32'd0);
      reset = 1'b1;
      saw_done = 0;
      repeat (70) begin
         @(negedge clk);
         if (done || out_valid) saw_done = 1;
      end
      check("abort_quiet", {31'd0, saw_done}, 32'd0);
      do_dump(1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
